game_controller: RTL and testbench

- Downstream consumer of the ball/paddle movement stage.
- Turns the per-frame collided/missed flags into game state: serve timing, rally hit count, remaining lives, best score and game-over.
- Drives hold_ball back into the movement stage so the ball is parked during serve and miss pauses.
- Runs on the pixel clock and qualifies all game events on a one-cycle frame tick derived from endofframe.

---
 rtl/game_controller.sv | 158 +++++++++++++++
 tb/tb_game_controller.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// Game-state controller downstream of the ball/paddle movement stage: serve timing,
// rally hit count, lives, best score and game-over, all qualified on a frame tick.
module game_controller #(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned MISS_FRAMES  = 90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       endofframe,
  input  logic       btn_start,
  input  logic       collided,
  input  logic       missed,
  output logic       frame_tick,
  output logic       hold_ball,
  output logic       play_active,
  output logic [7:0] hits_bcd,
  output logic [7:0] best_bcd,
  output logic [1:0] lives,
  output logic       game_over,
  output logic [2:0] state
);

  localparam logic [1:0] LivesInit = 2'(LIVES);
  localparam logic [7:0] ServeLast = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] MissLast  = 8'(MISS_FRAMES - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StPlay  = 3'd2,
    StMiss  = 3'd3,
    StOver  = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic       endofframe_q;
  logic       btn_start_q;
  logic       collided_prev_q;
  logic [7:0] frame_cnt_q;
  logic [7:0] hits_next;
  logic       start_pulse;
  logic       hit_event;
  logic       miss_event;
  logic       best_lower;

  assign state       = state_q;
  assign start_pulse = btn_start & ~btn_start_q;
  assign miss_event  = frame_tick & missed & (state_q == StPlay);
  // A held collision counts once; a simultaneous miss suppresses the hit.
  assign hit_event   = frame_tick & collided & ~collided_prev_q & ~missed & (state_q == StPlay);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      endofframe_q <= 1'b0;
      btn_start_q  <= 1'b0;
      frame_tick   <= 1'b0;
    end else begin
      endofframe_q <= endofframe;
      btn_start_q  <= btn_start;
      frame_tick   <= endofframe & ~endofframe_q;
    end
  end

  // Saturating two-digit BCD increment.
  always_comb begin
    hits_next = hits_bcd;
    if (hits_bcd == 8'h99) begin
      hits_next = hits_bcd;
    end else if (hits_bcd[3:0] >= 4'd9) begin
      hits_next = {hits_bcd[7:4] + 4'd1, 4'd0};
    end else begin
      hits_next = {hits_bcd[7:4], hits_bcd[3:0] + 4'd1};
    end
  end

  assign best_lower = (hits_bcd[7:4] > best_bcd[7:4]) ||
                      ((hits_bcd[7:4] == best_bcd[7:4]) && (hits_bcd[3:0] > best_bcd[3:0]));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      best_bcd <= 8'h00;
    end else if (best_lower) begin
      best_bcd <= hits_bcd;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StOver: if (start_pulse) state_d = StServe;
      StServe: if (frame_tick && frame_cnt_q == ServeLast) state_d = StPlay;
      StPlay:  if (miss_event) state_d = StMiss;
      StMiss: begin
        if (frame_tick && frame_cnt_q == MissLast) begin
          state_d = (lives == 2'd0) ? StOver : StServe;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= StIdle;
      hold_ball       <= 1'b1;
      play_active     <= 1'b0;
      game_over       <= 1'b0;
      hits_bcd        <= 8'h00;
      lives           <= LivesInit;
      frame_cnt_q     <= 8'd0;
      collided_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_ball   <= (state_d != StPlay);
      play_active <= (state_d == StPlay);
      game_over   <= (state_d == StOver);
      unique case (state_q)
        StIdle, StOver: begin
          if (start_pulse) begin
            hits_bcd        <= 8'h00;
            lives           <= LivesInit;
            frame_cnt_q     <= 8'd0;
            collided_prev_q <= 1'b0;
          end
        end
        StServe: begin
          if (frame_tick) begin
            frame_cnt_q <= (frame_cnt_q == ServeLast) ? 8'd0 : frame_cnt_q + 8'd1;
          end
        end
        StPlay: begin
          if (frame_tick) begin
            collided_prev_q <= collided;
            if (miss_event) begin
              frame_cnt_q <= 8'd0;
              if (lives != 2'd0) lives <= lives - 2'd1;
            end else if (hit_event) begin
              hits_bcd <= hits_next;
            end
          end
        end
        StMiss: begin
          if (frame_tick) begin
            if (frame_cnt_q == MissLast) begin
              frame_cnt_q     <= 8'd0;
              collided_prev_q <= 1'b0;
            end else begin
              frame_cnt_q <= frame_cnt_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller: behavioural model feeding a scoreboard queue,
// a vector table for the rally-hit sequence, and directed multi-cycle sequences.
module tb_game_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       endofframe, btn_start, collided, missed;
  logic       frame_tick, hold_ball, play_active, game_over;
  logic [7:0] hits_bcd, best_bcd;
  logic [1:0] lives;
  logic [2:0] state;

  game_controller #(
    .LIVES       (3),
    .SERVE_FRAMES(60),
    .MISS_FRAMES (90)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .endofframe (endofframe),
    .btn_start  (btn_start),
    .collided   (collided),
    .missed     (missed),
    .frame_tick (frame_tick),
    .hold_ball  (hold_ball),
    .play_active(play_active),
    .hits_bcd   (hits_bcd),
    .best_bcd   (best_bcd),
    .lives      (lives),
    .game_over  (game_over),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic [7:0] hits;
    logic [7:0] best;
    logic [1:0] lv;
  } exp_t;

  typedef struct {
    logic       col;
    logic       mis;
    logic [7:0] hits;
    logic [2:0] st;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[7];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model, kept in plain decimal integers.
  int   m_st, m_cnt, m_hits, m_best, m_lives;
  bit   m_prev;

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_hits = 0; m_best = 0; m_lives = 3; m_prev = 0;
  endtask

  task automatic model_start();
    if (m_st == 0 || m_st == 4) begin
      m_st = 1; m_cnt = 0; m_hits = 0; m_lives = 3; m_prev = 0;
    end
  endtask

  task automatic model_tick(input logic col, input logic mis);
    case (m_st)
      1: if (m_cnt == 59) begin m_st = 2; m_cnt = 0; end else m_cnt++;
      2: begin
        if (mis) begin
          if (m_lives > 0) m_lives--;
          m_st = 3; m_cnt = 0;
        end else if (col && !m_prev && m_hits < 99) begin
          m_hits++;
        end
        m_prev = col;
      end
      3: if (m_cnt == 89) begin
           m_st = (m_lives == 0) ? 4 : 1; m_cnt = 0; m_prev = 0;
         end else m_cnt++;
      default: ;
    endcase
    if (m_hits > m_best) m_best = m_hits;
  endtask

  task automatic sb_check();
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_empty", 8'd1, 8'd0);
    end else begin
      e = sbq.pop_front();
      chk("sb_state", {5'd0, state}, {5'd0, e.st});
      chk("sb_hits", hits_bcd, e.hits);
      chk("sb_best", best_bcd, e.best);
      chk("sb_lives", {6'd0, lives}, {6'd0, e.lv});
      chk("sb_hold", {7'd0, hold_ball}, {7'd0, (e.st != 3'd2)});
      chk("sb_play", {7'd0, play_active}, {7'd0, (e.st == 3'd2)});
      chk("sb_over", {7'd0, game_over}, {7'd0, (e.st == 3'd4)});
    end
  endtask

  // One frame: starts and ends on a falling clock edge.
  task automatic frame(input logic col, input logic mis);
    exp_t e;
    collided   = col;
    missed     = mis;
    endofframe = 1'b1;
    @(negedge clk);
    chk("tick_high", {7'd0, frame_tick}, 8'd1);
    model_tick(col, mis);
    e.st = 3'(m_st); e.hits = to_bcd(m_hits); e.best = to_bcd(m_best); e.lv = 2'(m_lives);
    sbq.push_back(e);
    @(negedge clk);
    chk("tick_one_cycle", {7'd0, frame_tick}, 8'd0);
    endofframe = 1'b0;
    @(negedge clk);
    sb_check();
  endtask

  task automatic frames(input int n);
    repeat (n) frame(1'b0, 1'b0);
  endtask

  task automatic hit();
    frame(1'b1, 1'b0);
    frame(1'b0, 1'b0);
  endtask

  task automatic press_start();
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
    model_start();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{col: 1'b1, mis: 1'b0, hits: 8'h01, st: 3'd2};
    tbl[1] = '{col: 1'b1, mis: 1'b0, hits: 8'h01, st: 3'd2};
    tbl[2] = '{col: 1'b1, mis: 1'b0, hits: 8'h01, st: 3'd2};
    tbl[3] = '{col: 1'b1, mis: 1'b0, hits: 8'h01, st: 3'd2};
    tbl[4] = '{col: 1'b0, mis: 1'b0, hits: 8'h01, st: 3'd2};
    tbl[5] = '{col: 1'b1, mis: 1'b0, hits: 8'h02, st: 3'd2};
    tbl[6] = '{col: 1'b0, mis: 1'b0, hits: 8'h02, st: 3'd2};

    endofframe = 1'b0; btn_start = 1'b0; collided = 1'b0; missed = 1'b0;
    @(negedge clk);
    do_reset();
    chk("rst_state", {5'd0, state}, 8'd0);
    chk("rst_hold", {7'd0, hold_ball}, 8'd1);
    chk("rst_lives", {6'd0, lives}, 8'd3);
    chk("rst_hits", hits_bcd, 8'h00);
    chk("rst_best", best_bcd, 8'h00);
    repeat (4) @(negedge clk);
    chk("no_tick_idle", {7'd0, frame_tick}, 8'd0);

    // Game 1: serve timing, hit counting, simultaneous hit+miss, saturation.
    press_start();
    chk("start_serve", {5'd0, state}, 8'd1);
    frames(59);
    chk("serve_tick59", {5'd0, state}, 8'd1);
    frame(1'b0, 1'b0);
    chk("serve_tick60", {5'd0, state}, 8'd2);
    chk("play_hold", {7'd0, hold_ball}, 8'd0);

    for (int i = 0; i < 7; i++) begin
      frame(tbl[i].col, tbl[i].mis);
      chk($sformatf("vec%0d_hits", i), hits_bcd, tbl[i].hits);
      chk($sformatf("vec%0d_state", i), {5'd0, state}, {5'd0, tbl[i].st});
    end

    while (m_hits < 8) hit();
    chk("hits_08", hits_bcd, 8'h08);
    repeat (2) hit();
    chk("hits_carry_10", hits_bcd, 8'h10);
    repeat (8) hit();
    chk("hits_18", hits_bcd, 8'h18);

    press_start();
    chk("start_ignored_play", {5'd0, state}, 8'd2);

    frame(1'b1, 1'b1);
    chk("both_hits", hits_bcd, 8'h18);
    chk("both_lives", {6'd0, lives}, 8'd2);
    chk("both_state", {5'd0, state}, 8'd3);
    frames(89);
    chk("miss_tick89", {5'd0, state}, 8'd3);
    frame(1'b0, 1'b0);
    chk("miss_to_serve", {5'd0, state}, 8'd1);
    frames(60);
    chk("reserve_play", {5'd0, state}, 8'd2);

    while (m_hits < 99) hit();
    chk("hits_99", hits_bcd, 8'h99);
    hit();
    chk("hits_sat", hits_bcd, 8'h99);
    chk("best_99", best_bcd, 8'h99);

    // Game 2: three lost lives with a rally of 12, then restart from OVER.
    do_reset();
    chk("rst2_best", best_bcd, 8'h00);
    press_start();
    for (int life = 0; life < 3; life++) begin
      frames(60);
      repeat (4) hit();
      frame(1'b0, 1'b1);
      chk($sformatf("lives_after_miss%0d", life), {6'd0, lives}, 8'(2 - life));
      frames(90);
    end
    chk("over_state", {5'd0, state}, 8'd4);
    chk("over_flag", {7'd0, game_over}, 8'd1);
    chk("over_hold", {7'd0, hold_ball}, 8'd1);
    chk("over_best", best_bcd, 8'h12);
    press_start();
    chk("restart_state", {5'd0, state}, 8'd1);
    chk("restart_hits", hits_bcd, 8'h00);
    chk("restart_lives", {6'd0, lives}, 8'd3);
    chk("restart_best", best_bcd, 8'h12);

    // Game 3: asynchronous reset in the middle of a miss pause.
    frames(60);
    hit();
    frame(1'b0, 1'b1);
    frames(40);
    chk("pre_reset_state", {5'd0, state}, 8'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("async_state", {5'd0, state}, 8'd0);
    chk("async_lives", {6'd0, lives}, 8'd3);
    chk("async_hits", hits_bcd, 8'h00);
    chk("async_hold", {7'd0, hold_ball}, 8'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_state", {5'd0, state}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
